// File: rtl/vs_stream_mux_nx1.sv
// Registered N:1 stream multiplexer with an internal round-robin or fixed-priority arbiter.
// A granted packet keeps the channel locked until its last beat has been accepted.
module vs_stream_mux_nx1 #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned RR_MODE = 1,
    localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]       s_valid,
    input  logic [NUM_CH-1:0]       s_last,
    output logic [NUM_CH-1:0]       s_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_last,
    output logic [SEL_W-1:0]        m_sel,
    output logic                    m_valid,
    input  logic                    m_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic             r_lock;
    logic [SEL_W-1:0] r_lock_idx;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_accept;
    logic [SEL_W-1:0] w_grant;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W-1:0] w_ptr_next;
    logic [WIDTH-1:0] w_data;
    logic             w_last;

    assign w_load_en = !r_valid || m_ready;
    assign w_accept  = w_load_en && w_grant_valid;

    // A locked channel owns the output even while its valid is low mid-packet.
    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        w_rr_idx      = '0;
        if (r_lock) begin
            w_grant       = r_lock_idx;
            w_grant_valid = s_valid[r_lock_idx];
        end else if (RR_MODE != 0) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                w_rr_idx = SEL_W'((32'(r_ptr) + k) % NUM_CH);
                if (!w_grant_valid && s_valid[w_rr_idx]) begin
                    w_grant       = w_rr_idx;
                    w_grant_valid = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (!w_grant_valid && s_valid[k]) begin
                    w_grant       = SEL_W'(k);
                    w_grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        w_last = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_data = s_data[i*WIDTH +: WIDTH];
                w_last = s_last[i];
            end
        end
    end

    // Gated by rst_n so no channel sees a ready while the block is held in reset.
    always_comb begin
        s_ready = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            s_ready[i] = rst_n && w_load_en && w_grant_valid && (w_grant == SEL_W'(i));
        end
    end

    assign w_ptr_next = (w_grant == SEL_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_last     <= 1'b0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_ptr      <= '0;
        end else if (w_load_en) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_data <= w_data;
                r_last <= w_last;
                r_sel  <= w_grant;
                if (w_last) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_ptr_next;
                end else begin
                    r_lock     <= 1'b1;
                    r_lock_idx <= w_grant;
                end
            end
        end
    end

    assign m_data  = r_data;
    assign m_last  = r_last;
    assign m_sel   = r_sel;
    assign m_valid = r_valid;

endmodule

// File: doc/vs_stream_mux_nx1.md
Name: vs_stream_mux_nx1

Overview:
- Registered N-input to 1-output stream multiplexer with valid/ready handshakes on every channel.
- Selection is made by an internal arbiter rather than an external select. The arbiter is round-robin or fixed-priority, chosen by parameter.
- A packet is held on one channel until its `last` beat completes.
- Sits between several producers and a single shared datapath consumer, for example bus bridges and DMA merge points.

Parameters:
- WIDTH, 8, data bits per channel.
- NUM_CH, 4, number of input channels; legal range 1..16.
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- SEL_W, localparam, max(1, $clog2(NUM_CH)).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- s_data, input, NUM_CH*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
- s_valid, input, NUM_CH, per-channel beat valid.
- s_last, input, NUM_CH, per-channel end-of-packet flag.
- s_ready, output, NUM_CH, per-channel accept; at most one bit high.
- m_data, output, WIDTH, registered output data.
- m_last, output, 1, registered end-of-packet flag.
- m_sel, output, SEL_W, index of the channel that sourced the current output beat.
- m_valid, output, 1, output beat valid.
- m_ready, input, 1, downstream accept.

Behaviour:
- **Reset.** rst_n low asynchronously clears m_valid, m_data, m_last, m_sel, lock flag, lock index and RR pointer to 0. s_ready is 0 while in reset.
- **Load enable.** load_en = !m_valid || m_ready. The output register updates only when load_en is 1.
- **Ready path.** s_ready[i] = load_en && grant_valid && (grant == i). This is combinational from m_ready, s_valid and state; there is no combinational path from s_data.
- **Transfers.** An input transfer on channel i occurs when s_valid[i] && s_ready[i]. An output transfer occurs when m_valid && m_ready.
- **Latency.** One cycle: a beat accepted in cycle t appears on m_data/m_last/m_sel in cycle t+1 with m_valid=1.
- **Register update.**
  - If load_en and an input transfer occur: load data, last and index, and set m_valid=1.
  - If load_en and no input transfer occur: m_valid goes to 0; data, last and sel hold their previous values.
  - Full throughput of 1 beat/cycle when m_ready is held high.
- **Arbitration, unlocked.**
  - grant_valid = |s_valid.
  - RR_MODE=1: search starts at the RR pointer, increments modulo NUM_CH, and the first asserted s_valid wins.
  - RR_MODE=0: the lowest asserted index wins and the pointer is ignored.
- **Arbitration, locked.** grant = lock index. grant_valid = s_valid[lock index]. Other channels are never granted, even if the locked channel deasserts valid mid-packet.
- **Lock.**
  - Accepting a beat with s_last=0 sets lock=1 and lock index = channel.
  - Accepting a beat with s_last=1 clears lock.
  - A single-beat packet (last=1 on the first beat) never sets lock.
- **RR pointer.** Updates only on acceptance of a last beat from channel g: pointer = (g+1) mod NUM_CH. Non-last beats leave it unchanged.
- **Stall.** While m_valid=1 and m_ready=0, all s_ready are 0. m_data, m_last and m_sel stay stable. Lock and pointer hold.
- **Simultaneous events.** An output transfer and an input transfer in the same cycle replace the register contents with no bubble. Lock set/clear and pointer update in that same cycle use the accepted beat.
- **NUM_CH=1.** Grant is always channel 0. m_sel is constant 0. Lock logic still tracks packets; the behaviour is equivalent to a one-stage pipeline register.
- **Mid-operation reset.** A partial packet is discarded, lock is cleared, and the pointer returns to 0. Upstream must resume from a packet boundary.
- **Input rules.** Inputs must not change s_data/s_last of a channel while its s_valid=1 and s_ready=0; behaviour otherwise is undefined. No assertion is required in RTL.

Test Plan:
- **Reset.** Assert rst_n=0 mid-stream with m_valid=1 -> m_valid, m_data, m_sel and s_ready go to 0 immediately. After release with all s_valid=0, outputs stay 0.
- **Round-robin fairness.** NUM_CH=4, RR_MODE=1, all channels send continuous single-beat packets (last=1), m_ready=1 -> m_sel sequence 0,1,2,3,0,1,…, one beat per cycle, one-cycle latency.
- **Packet lock.** Channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is valid throughout -> m_sel=2 for three consecutive beats, then 0. The pointer becomes 3 after the last beat, so the next contention between channels 0 and 3 grants 3.
- **Fixed priority.** RR_MODE=0, channels 1 and 3 continuously valid with single-beat packets -> channel 3 never granted while channel 1 is valid; m_sel is always 1.
- **Backpressure.** Hold m_ready=0 for 5 cycles with m_valid=1 and data 0xA5 -> m_data stays 0xA5, all s_ready=0. On the cycle m_ready returns to 1, the next beat loads with no bubble.
- **Locked gap.** A locked channel deasserts s_valid for 2 cycles mid-packet while other channels are valid -> m_valid drops to 0 and no other channel is granted. The packet resumes on the same m_sel.
